// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: PC owner and 2-cycle fetch/execute sequencer with Start/Done handshake.
// Define FETCH_PERF_CNT_EN to add saturating CycleCount/InstrCount outputs.
module instr_fetch_seq #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter logic [8:0]      NOP_WORD = 9'b0_011_00000
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  output logic [PC_W-1:0] ImemAddr,
  output logic            ImemRdEn,
  input  logic [8:0]      ImemData,
  output logic [8:0]      Instruction_out,
  output logic            ExecValid,
  input  logic            Stall,
  input  logic            PC_Next_Sel,
  input  logic [4:0]      BranchOffset,
  input  logic            JumpIndirect,
  input  logic [PC_W-1:0] JumpTarget,
  input  logic            DoneIn,
  output logic [PC_W-1:0] PC_out,
  output logic [PC_W-1:0] PC_Plus1,
  output logic            Done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     CycleCount,
  output logic [31:0]     InstrCount
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;
  state_t state;
  logic [PC_W-1:0] pc, next_pc;
  logic [8:0] ir;
  logic start_ok, exec_exit;
  assign start_ok = Start && (state == IDLE || state == HALTED);
  assign exec_exit = state == EXEC && !Stall;
  assign PC_out = pc;
  assign PC_Plus1 = pc + PC_W'(1);
  assign ImemAddr = pc;
  assign Instruction_out = ir;
  always_comb next_pc = !PC_Next_Sel ? PC_Plus1 : JumpIndirect ? JumpTarget : pc + {{(PC_W-5){BranchOffset[4]}}, BranchOffset};
  // ir doubles as the decoder feed: it only holds a fetched word while in EXEC
  always_ff @(posedge Clk)
    if (Reset) begin
      state <= IDLE;
      pc <= START_PC;
      ir <= NOP_WORD;
      Done <= 1'b0;
      ImemRdEn <= 1'b0;
      ExecValid <= 1'b0;
    end else if (start_ok) begin
      state <= FETCH;
      pc <= START_PC;
      Done <= 1'b0;
      ImemRdEn <= 1'b1;
    end else if (state == FETCH) begin
      state <= EXEC;
      ir <= ImemData;
      ImemRdEn <= 1'b0;
      ExecValid <= 1'b1;
    end else if (exec_exit) begin
      state <= DoneIn ? HALTED : FETCH;
      pc <= DoneIn ? pc : next_pc;
      Done <= DoneIn;
      ir <= NOP_WORD;
      ImemRdEn <= !DoneIn;
      ExecValid <= 1'b0;
    end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clk)
    if (Reset || start_ok) begin
      CycleCount <= '0;
      InstrCount <= '0;
    end else begin
      if ((state == FETCH || state == EXEC) && !(&CycleCount)) CycleCount <= CycleCount + 32'd1;
      if (exec_exit && !(&InstrCount)) InstrCount <= InstrCount + 32'd1;
    end
`endif
endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Program sequencer that feeds the control decoder: owns the PC, reads 9-bit machine code from a synchronous-read instruction memory, and presents one instruction per execute cycle on Instruction_out.
- Consumes the decoder's flow-control outputs (PC_Next_Sel, BranchOffset, Done) plus a top-level indirect-jump select.
- Runs the Start/Done handshake for the whole CPU.
- Sits between instruction memory and the decoder at top level.

Parameters:
- PC_W, 10, PC and instruction-memory address width; PC arithmetic is modulo 2^PC_W.
- START_PC, 0, PC loaded on each accepted Start.
- NOP_WORD, 9'b0_011_00000, word driven on Instruction_out outside EXEC (decodes to no side effects).

Ports:
- Clk  in  1  clock, all state on rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  run request, sampled in IDLE/HALTED only.
- ImemAddr  out  PC_W  instruction-memory read address.
- ImemRdEn  out  1  read strobe; data valid on ImemData the following cycle.
- ImemData  in  9  read data.
- Instruction_out  out  9  to decoder Instruction_in.
- ExecValid  out  1  high only in EXEC; top level ANDs it into all register/memory write enables.
- Stall  in  1  holds EXEC (multi-cycle ALU/FPU op).
- PC_Next_Sel  in  1  from decoder: take branch/jump.
- BranchOffset  in  5  from decoder, two's complement.
- JumpIndirect  in  1  from top level: target is JumpTarget, not relative.
- JumpTarget  in  PC_W  register-file data for JAL.
- DoneIn  in  1  decoder HALT decode.
- PC_out  out  PC_W  current instruction PC.
- PC_Plus1  out  PC_W  PC+1 (wraps), link value for JAL.
- Done  out  1  sticky halt indication.

Behaviour:
- Reset (synchronous, active-high, any state): state=IDLE, PC=START_PC, IR=NOP_WORD, Done=0, ImemRdEn=0, ExecValid=0. An in-flight fetch is discarded.
- States: IDLE, FETCH, EXEC, HALTED.
- IDLE: Start=1 -> PC<=START_PC, go to FETCH, Done<=0.
- FETCH (1 cycle): ImemAddr=PC, ImemRdEn=1. Next cycle -> EXEC; IR<=ImemData is captured on that entering edge.
- EXEC: Instruction_out=IR, ExecValid=1. Decoder outputs are sampled at the end of the cycle.
  - Stall=1: remain in EXEC; IR and PC hold; ExecValid stays 1.
  - DoneIn=1 (priority over branch): go to HALTED, Done<=1, PC holds at the HALT address.
  - Else if PC_Next_Sel=1 and JumpIndirect=1: PC<=JumpTarget.
  - Else if PC_Next_Sel=1: PC<=PC+sign_extend(BranchOffset) mod 2^PC_W (range -16..+15; offset 0 means branch-to-self).
  - Else: PC<=PC+1 mod 2^PC_W.
  - Any non-halt case goes to FETCH.
- Throughput: exactly 2 cycles per instruction without stall. Latency from Start to first ExecValid is 2 cycles.
- HALTED: Done=1 held; Instruction_out=NOP_WORD. Start=1 restarts at START_PC (Done clears on the same edge).
- Start is ignored in FETCH/EXEC.
- Outside EXEC, Instruction_out=NOP_WORD and ExecValid=0.
- ImemAddr=PC in all states; ImemRdEn=1 only in FETCH.
- PC_out=PC and PC_Plus1=PC+1 are combinational from the PC register.
- Wrap: PC=2^PC_W-1 with sequential flow gives 0. Negative offsets below 0 wrap to the top of memory.
- Stall in a non-EXEC state has no effect.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds outputs CycleCount[31:0] (increments every cycle in FETCH/EXEC) and InstrCount[31:0] (increments on each EXEC exit, stall cycles excluded). Both clear on Reset and on accepted Start, hold in IDLE/HALTED, and saturate at all-ones.
- Not defined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then Start pulse; memory holds 3 NOPs then 9'b1_111_00000 at addr 3 -> ExecValid pulses at cycles 2,4,6,8; Done=1 after cycle 8; PC_out=3 held.
- Branch at PC=5 with PC_Next_Sel=1, BranchOffset=5'b11110 -> next FETCH address 3. Repeat with offset 5'b01111 -> address 20.
- JAL at PC=7 with JumpIndirect=1, JumpTarget=100 -> PC_Plus1=8 during EXEC; next ImemAddr=100.
- Stall held 3 cycles in EXEC -> Instruction_out and PC unchanged, ExecValid=1 for 4 cycles total, then normal advance.
- PC=1023 (PC_W=10) with sequential flow -> next fetch at 0. Offset -2 at PC=0 -> 1022.
- Reset asserted during FETCH -> next cycle in IDLE, Instruction_out=NOP_WORD, ImemRdEn=0; Start in EXEC is ignored; Start in HALTED restarts at START_PC and clears Done.
